// File: rtl/scu_dsp_dma_ctrl.sv
// ---------------------------------------------------------------------------
// scu_dsp_dma_ctrl
//
// Sequencer for the SCU DSP DMA opcodes. One accepted command is executed as
// a series of single 32-bit word transfers between the external bus (D0) and
// either one of the four DSP data RAM banks or the DSP program RAM.
//
//   D0 -> RAM : XRD (bus read) -> RWR (RAM write) -> ... -> DONE
//   RAM -> D0 : RRD (RAM read) -> RLAT (capture)  -> XWR (bus write) -> ... -> DONE
//
// After the last word, DONE issues an address write-back pulse (unless HOLD
// was set) carrying the final external address for RA0/WA0.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   ce                  clock enable; state and registers only move when ce=1
//   start               command issue strobe (sampled with ce=1 in IDLE only)
//   dir                 0: D0 -> RAM, 1: RAM -> D0
//   ram_sel             0-3 data RAM bank, 4 program RAM, 5-7 reserved
//   add_mode            external address step code (0,4,8,...,256 bytes)
//   cnt                 word count, 0 encodes 256
//   hold                1: suppress the address write-back
//   addr_in             start external byte address
//   busy                command in progress
//   ext_req/ext_we      external bus request / write qualifier
//   ext_addr/ext_do     external address / write data
//   ext_di/ext_ack      external read data / transfer acknowledge
//   ram_we/ram_re       one-hot data RAM write / read strobes
//   ram_inc             one-hot CT increment pulse for the selected bank
//   ram_do/ram_di       data RAM (and program RAM) write data / read data
//   prg_we/prg_addr     program RAM write strobe / word address
//   addr_wb/addr_out    write-back pulse / final external address
//   dbg_state           current FSM state (debug visibility)
//
// External handshake: ext_req is raised in XRD/XWR and held, together with a
// stable ext_addr, ext_we and ext_do, until a cycle where ext_req=1, ext_ack=1
// and ce=1 coincide; that cycle completes the transfer. ext_ack may be
// combinational and arrive in the very first request cycle. ext_ack seen
// while ext_req=0 or ce=0 is ignored.
// ---------------------------------------------------------------------------
module scu_dsp_dma_ctrl #(
  parameter int ADDR_W = 27,
  parameter int PRG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic              dir,
  input  logic [2:0]        ram_sel,
  input  logic [2:0]        add_mode,
  input  logic [7:0]        cnt,
  input  logic              hold,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              busy,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [31:0]       ext_do,
  input  logic [31:0]       ext_di,
  input  logic              ext_ack,
  output logic [3:0]        ram_we,
  output logic [3:0]        ram_re,
  output logic [3:0]        ram_inc,
  output logic [31:0]       ram_do,
  input  logic [31:0]       ram_di,
  output logic              prg_we,
  output logic [PRG_AW-1:0] prg_addr,
  output logic              addr_wb,
  output logic [ADDR_W-1:0] addr_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XRD  = 3'd1,
    S_RWR  = 3'd2,
    S_RRD  = 3'd3,
    S_RLAT = 3'd4,
    S_XWR  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Command registers, loaded when a command is accepted in IDLE.
  logic [2:0]        sel_q;
  logic [8:0]        step_q;
  logic [8:0]        cnt_q;      // 9 bits so that a count of 256 is representable
  logic              hold_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [PRG_AW-1:0] prg_addr_q;

  logic       start_ok;
  logic       last_word;
  logic       sel_prg;
  logic [3:0] bank_oh;

  // Step in bytes: code 0 repeats the address, codes 1..7 give 4..256.
  function automatic logic [8:0] step_of(input logic [2:0] m);
    if (m == 3'd0) return 9'd0;
    return 9'd2 << m;
  endfunction

  // Reserved selects and program-RAM reads are not valid commands and are
  // dropped without leaving IDLE.
  assign start_ok  = start && ((ram_sel < 3'd4) || ((ram_sel == 3'd4) && !dir));
  assign last_word = (cnt_q == 9'd1);
  assign sel_prg   = (sel_q == 3'd4);
  // Program RAM (sel 4) maps to no data bank, so it never strobes RAM_WE/RE/INC.
  assign bank_oh   = sel_q[2] ? 4'b0000 : (4'b0001 << sel_q[1:0]);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = dir ? S_RRD : S_XRD;
      end
      S_XRD: begin
        if (ext_ack) state_d = S_RWR;
      end
      S_RWR: begin
        state_d = last_word ? S_DONE : S_XRD;
      end
      S_RRD: begin
        state_d = S_RLAT;
      end
      S_RLAT: begin
        state_d = S_XWR;
      end
      S_XWR: begin
        if (ext_ack) state_d = last_word ? S_DONE : S_RRD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= 3'd0;
      step_q     <= 9'd0;
      cnt_q      <= 9'd0;
      hold_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      prg_addr_q <= '0;
    end else if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            sel_q      <= ram_sel;
            step_q     <= step_of(add_mode);
            cnt_q      <= (cnt == 8'd0) ? 9'd256 : {1'b0, cnt};
            hold_q     <= hold;
            addr_q     <= addr_in;
            prg_addr_q <= '0;
          end
        end
        S_XRD: begin
          if (ext_ack) data_q <= ext_di;
        end
        S_RWR: begin
          // Address arithmetic wraps naturally at the register width.
          addr_q <= addr_q + ADDR_W'(step_q);
          cnt_q  <= cnt_q - 9'd1;
          if (sel_prg) prg_addr_q <= prg_addr_q + PRG_AW'(1);
        end
        S_RLAT: begin
          data_q <= ram_di;
        end
        S_XWR: begin
          if (ext_ack) begin
            addr_q <= addr_q + ADDR_W'(step_q);
            cnt_q  <= cnt_q - 9'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Strobes are qualified with ce so that each is exactly one
  // enabled cycle wide; level outputs decode the state directly, so an
  // asynchronous reset clears them immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    busy    = (state_q != S_IDLE);
    ext_req = (state_q == S_XRD) || (state_q == S_XWR);
    ext_we  = (state_q == S_XWR);
    ram_we  = 4'b0000;
    ram_re  = 4'b0000;
    ram_inc = 4'b0000;
    prg_we  = 1'b0;
    addr_wb = 1'b0;
    if (ce) begin
      case (state_q)
        S_RWR: begin
          ram_we  = bank_oh;
          ram_inc = bank_oh;
          prg_we  = sel_prg;
        end
        S_RRD: begin
          ram_re  = bank_oh;
          ram_inc = bank_oh;
        end
        S_DONE: begin
          addr_wb = !hold_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign ext_addr  = addr_q;
  assign ext_do    = data_q;
  assign ram_do    = data_q;
  assign prg_addr  = prg_addr_q;
  assign addr_out  = addr_q;
  assign dbg_state = state_q;

endmodule
